// File: rtl/reg_op_sequencer_pkg.sv
// Shared constants and types for the register-file micro-op sequencer:
// opcode values, REGBOPX encodings, default widths and the FSM state type.
package reg_op_sequencer_pkg;

    localparam int DW_DEF     = 16;
    localparam int AW_DEF     = 4;
    localparam int PC_IDX_DEF = 15;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_LOAD  = 3'b001;
    localparam logic [2:0] OP_INC   = 3'b010;
    localparam logic [2:0] OP_DEC   = 3'b011;
    localparam logic [2:0] OP_MOVE  = 3'b100;
    localparam logic [2:0] OP_SWAP  = 3'b101;
    localparam logic [2:0] OP_LDINC = 3'b110;
    localparam logic [2:0] OP_RSVD  = 3'b111;

    localparam logic [1:0] BOP_NONE = 2'b00;
    localparam logic [1:0] BOP_DEC  = 2'b01;
    localparam logic [1:0] BOP_INC  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EX1  = 2'd1,
        ST_EX2  = 2'd2,
        ST_EX3  = 2'd3
    } state_e;

endpackage

// File: rtl/reg_op_sequencer_if.sv
// Bundle of the decoder-side handshake and the register-file control/data
// signals. The sequencer uses the slave view; the decoder/register-file
// environment uses the master view.
interface reg_op_sequencer_if
    import reg_op_sequencer_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
);
    logic          OP_VALID;
    logic          OP_READY;
    logic [2:0]    OP_CODE;
    logic [AW-1:0] OP_RA;
    logic [AW-1:0] OP_RB;
    logic [DW-1:0] OP_DATA;
    logic          OP_DONE;
    logic          OP_ERR;
    logic [DW-1:0] DOUT_A;
    logic [DW-1:0] DOUT_B;
    logic [AW-1:0] REGAX;
    logic          REGAOPX;
    logic [AW-1:0] REGBX;
    logic [1:0]    REGBOPX;
    logic [DW-1:0] DIN;

    modport master (
        output OP_VALID, OP_CODE, OP_RA, OP_RB, OP_DATA, DOUT_A, DOUT_B,
        input  OP_READY, OP_DONE, OP_ERR, REGAX, REGAOPX, REGBX, REGBOPX, DIN
    );

    modport slave (
        input  OP_VALID, OP_CODE, OP_RA, OP_RB, OP_DATA, DOUT_A, DOUT_B,
        output OP_READY, OP_DONE, OP_ERR, REGAX, REGAOPX, REGBX, REGBOPX, DIN
    );

endinterface

// File: rtl/reg_op_sequencer_decode.sv
// Combinational classification of an incoming micro-op: how many execute
// cycles it needs, whether it is legal, and whether RA and RB collide.
module reg_op_sequencer_decode
    import reg_op_sequencer_pkg::*;
#(
    parameter int AW     = AW_DEF,
    parameter int PC_IDX = PC_IDX_DEF
) (
    input  logic [2:0]    op_code,
    input  logic [AW-1:0] op_ra,
    input  logic [AW-1:0] op_rb,
    output logic [1:0]    op_len,
    output logic          op_legal,
    output logic          same_reg
);

    typedef logic [AW-1:0] idx_t;
    localparam idx_t PC_SEL = idx_t'(PC_IDX);

    logic rb_is_pc;

    // Length and legality per opcode; a colliding SWAP collapses to the RA load only.
    always_comb begin
        op_len   = 2'd1;
        op_legal = 1'b1;
        same_reg = (op_ra == op_rb);
        rb_is_pc = (op_rb == PC_SEL);
        case (op_code)
            OP_NOP, OP_LOAD: begin
                op_len   = 2'd1;
                op_legal = 1'b1;
            end
            OP_INC, OP_DEC, OP_LDINC: begin
                op_len   = 2'd1;
                op_legal = !rb_is_pc;
            end
            OP_MOVE: begin
                op_len   = 2'd2;
                op_legal = 1'b1;
            end
            OP_SWAP: begin
                op_len   = same_reg ? 2'd2 : 2'd3;
                op_legal = 1'b1;
            end
            OP_RSVD: begin
                op_len   = 2'd1;
                op_legal = 1'b0;
            end
            default: begin
                op_len   = 2'd1;
                op_legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/reg_op_sequencer.sv
// Register-file micro-op sequencer. Accepts one op per valid/ready handshake
// and drives the register-file controls over 1-3 execute cycles. Every output
// is a flop; the values for execute cycle k are computed on the edge that
// ends cycle k-1, so B-side read data lands straight in the DIN register
// (acting as the B temporary) while the A-side read is held in ta_q.
module reg_op_sequencer
    import reg_op_sequencer_pkg::*;
#(
    parameter int DW     = DW_DEF,
    parameter int AW     = AW_DEF,
    parameter int PC_IDX = PC_IDX_DEF
) (
    input  logic              CLK,
    input  logic              RESET,
    reg_op_sequencer_if.slave bus
);

    state_e        state_q, state_d;
    logic          ready_q, ready_d;
    logic [AW-1:0] ra_q, ra_d;
    logic [AW-1:0] rb_q, rb_d;
    logic [1:0]    len_q, len_d;
    logic [DW-1:0] ta_q, ta_d;
    logic [AW-1:0] regax_q, regax_d;
    logic [AW-1:0] regbx_q, regbx_d;
    logic          aop_q, aop_d;
    logic [1:0]    bop_q, bop_d;
    logic [DW-1:0] din_q, din_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic [1:0]    dec_len_s;
    logic          dec_legal_s;
    logic          dec_same_s;

    reg_op_sequencer_decode #(
        .AW     (AW),
        .PC_IDX (PC_IDX)
    ) u_decode (
        .op_code  (bus.OP_CODE),
        .op_ra    (bus.OP_RA),
        .op_rb    (bus.OP_RB),
        .op_len   (dec_len_s),
        .op_legal (dec_legal_s),
        .same_reg (dec_same_s)
    );

    // Next-state and next-output computation for the execute sequence.
    always_comb begin
        state_d = state_q;
        ready_d = ready_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        len_d   = len_q;
        ta_d    = ta_q;
        regax_d = regax_q;
        regbx_d = regbx_q;
        aop_d   = 1'b0;
        bop_d   = BOP_NONE;
        din_d   = {DW{1'b0}};
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.OP_VALID && ready_q) begin
                    state_d = ST_EX1;
                    ready_d = 1'b0;
                    ra_d    = bus.OP_RA;
                    rb_d    = bus.OP_RB;
                    len_d   = dec_len_s;
                    if (!dec_legal_s) begin
                        err_d = 1'b1;
                    end else begin
                        case (bus.OP_CODE)
                            OP_NOP: begin
                                done_d = 1'b1;
                            end
                            OP_LOAD: begin
                                regax_d = bus.OP_RA;
                                din_d   = bus.OP_DATA;
                                aop_d   = 1'b1;
                                done_d  = 1'b1;
                            end
                            OP_INC: begin
                                regbx_d = bus.OP_RB;
                                bop_d   = BOP_INC;
                                done_d  = 1'b1;
                            end
                            OP_DEC: begin
                                regbx_d = bus.OP_RB;
                                bop_d   = BOP_DEC;
                                done_d  = 1'b1;
                            end
                            OP_MOVE: begin
                                regbx_d = bus.OP_RB;
                            end
                            OP_SWAP: begin
                                regax_d = bus.OP_RA;
                                regbx_d = bus.OP_RB;
                            end
                            OP_LDINC: begin
                                regax_d = bus.OP_RA;
                                din_d   = bus.OP_DATA;
                                aop_d   = 1'b1;
                                regbx_d = bus.OP_RB;
                                bop_d   = dec_same_s ? BOP_NONE : BOP_INC;
                                done_d  = 1'b1;
                            end
                            default: begin
                                err_d = 1'b1;
                            end
                        endcase
                    end
                end else begin
                    ready_d = 1'b1;
                end
            end
            ST_EX1: begin
                if (len_q == 2'd1) begin
                    state_d = ST_IDLE;
                    ready_d = 1'b1;
                end else begin
                    // MOVE and SWAP both write RA with the captured B value next.
                    state_d = ST_EX2;
                    ta_d    = bus.DOUT_A;
                    regax_d = ra_q;
                    din_d   = bus.DOUT_B;
                    aop_d   = 1'b1;
                    done_d  = (len_q == 2'd2);
                end
            end
            ST_EX2: begin
                if (len_q == 2'd3) begin
                    state_d = ST_EX3;
                    regax_d = rb_q;
                    din_d   = ta_q;
                    aop_d   = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    ready_d = 1'b1;
                end
            end
            ST_EX3: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    // State, operand and output registers; RESET drops any pending writes.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b0;
            ra_q    <= {AW{1'b0}};
            rb_q    <= {AW{1'b0}};
            len_q   <= 2'd0;
            ta_q    <= {DW{1'b0}};
            regax_q <= {AW{1'b0}};
            regbx_q <= {AW{1'b0}};
            aop_q   <= 1'b0;
            bop_q   <= BOP_NONE;
            din_q   <= {DW{1'b0}};
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            len_q   <= len_d;
            ta_q    <= ta_d;
            regax_q <= regax_d;
            regbx_q <= regbx_d;
            aop_q   <= aop_d;
            bop_q   <= bop_d;
            din_q   <= din_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.OP_READY = ready_q;
    assign bus.OP_DONE  = done_q;
    assign bus.OP_ERR   = err_q;
    assign bus.REGAX    = regax_q;
    assign bus.REGAOPX  = aop_q;
    assign bus.REGBX    = regbx_q;
    assign bus.REGBOPX  = bop_q;
    assign bus.DIN      = din_q;

endmodule

// File: tb/tb_reg_op_sequencer.sv
// Bench for reg_op_sequencer: a behavioural 16x16 register file (R15 auto-
// increments) is driven by the DUT, and an op-level model predicts the output
// frame of every cycle plus the register contents.
module tb_reg_op_sequencer;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    reg_op_sequencer_if #(.DW(16), .AW(4)) bus_if ();

    reg_op_sequencer #(.DW(16), .AW(4), .PC_IDX(15)) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus_if)
    );

    // Environment register file
    logic [15:0] rf [16];
    logic [15:0] init_vals [16];
    logic        rf_init;

    assign bus_if.DOUT_A = rf[bus_if.REGAX];
    assign bus_if.DOUT_B = rf[bus_if.REGBX];

    // Register file: PC increment, then inc/dec, then load (load wins on PC).
    always @(posedge clk) begin
        if (rf_init) begin
            for (int i = 0; i < 16; i++) rf[i] <= init_vals[i];
        end else begin
            rf[15] <= rf[15] + 16'd1;
            if (bus_if.REGBOPX[0])
                rf[bus_if.REGBX] <= bus_if.REGBOPX[1] ? rf[bus_if.REGBX] + 16'd1
                                                       : rf[bus_if.REGBX] - 16'd1;
            if (bus_if.REGAOPX) rf[bus_if.REGAX] <= bus_if.DIN;
        end
    end

    // Op-level model
    typedef struct {
        logic        ax_set;
        logic [3:0]  ax;
        logic        bx_set;
        logic [3:0]  bx;
        logic        aop;
        logic [1:0]  bop;
        logic [15:0] din;
        logic        done;
        logic        err;
    } frame_t;

    frame_t      plan[$];
    frame_t      cur;
    logic [15:0] model_rf [16];
    logic [3:0]  m_ax, m_bx;
    logic        m_ready;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [3:0]  s_ax;
    logic        s_aop, s_done, s_err;
    logic [1:0]  s_bop;
    logic [15:0] s_din;
    int          s_busy;

    function automatic frame_t idle_f();
        frame_t f;
        f = '{default: '0};
        return f;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Frames for an accepted op, from the opcode rules; model_rf is the state
    // the register file holds during the first execute cycle.
    task automatic build_plan(input logic [2:0] c, input logic [3:0] ra, input logic [3:0] rb,
                              input logic [15:0] data);
        frame_t f;
        logic [15:0] ta, tb;
        f = idle_f();
        case (c)
            3'd0: begin f.done = 1'b1; plan.push_back(f); end
            3'd1: begin
                f.ax_set = 1'b1; f.ax = ra; f.aop = 1'b1; f.din = data; f.done = 1'b1;
                plan.push_back(f);
            end
            3'd2, 3'd3: begin
                if (rb == 4'd15) begin
                    f.err = 1'b1;
                end else begin
                    f.bx_set = 1'b1; f.bx = rb; f.done = 1'b1;
                    f.bop = (c == 3'd2) ? 2'b11 : 2'b01;
                end
                plan.push_back(f);
            end
            3'd4: begin
                f.bx_set = 1'b1; f.bx = rb;
                plan.push_back(f);
                f = idle_f();
                f.ax_set = 1'b1; f.ax = ra; f.aop = 1'b1; f.din = model_rf[rb]; f.done = 1'b1;
                plan.push_back(f);
            end
            3'd5: begin
                ta = model_rf[ra];
                tb = model_rf[rb];
                f.ax_set = 1'b1; f.ax = ra; f.bx_set = 1'b1; f.bx = rb;
                plan.push_back(f);
                f = idle_f();
                f.ax_set = 1'b1; f.ax = ra; f.aop = 1'b1; f.din = tb; f.done = (ra == rb);
                plan.push_back(f);
                if (ra != rb) begin
                    f = idle_f();
                    f.ax_set = 1'b1; f.ax = rb; f.aop = 1'b1; f.din = ta; f.done = 1'b1;
                    plan.push_back(f);
                end
            end
            3'd6: begin
                if (rb == 4'd15) begin
                    f.err = 1'b1;
                end else begin
                    f.ax_set = 1'b1; f.ax = ra; f.aop = 1'b1; f.din = data;
                    f.bx_set = 1'b1; f.bx = rb; f.done = 1'b1;
                    f.bop = (ra == rb) ? 2'b00 : 2'b11;
                end
                plan.push_back(f);
            end
            default: begin f.err = 1'b1; plan.push_back(f); end
        endcase
    endtask

    // One clock: advance the model across the edge, then compare every output.
    task automatic cycle();
        frame_t f;
        logic   nready;
        logic   was_rst;
        int     k;
        was_rst = rst;
        model_rf[15] = model_rf[15] + 16'd1;
        if (cur.bop[0])
            model_rf[m_bx] = cur.bop[1] ? model_rf[m_bx] + 16'd1 : model_rf[m_bx] - 16'd1;
        if (cur.aop) model_rf[m_ax] = cur.din;
        if (was_rst) begin
            plan.delete();
            f = idle_f();
            nready = 1'b0;
        end else if (plan.size() != 0) begin
            f = plan.pop_front();
            nready = 1'b0;
        end else if (bus_if.OP_VALID && m_ready) begin
            build_plan(bus_if.OP_CODE, bus_if.OP_RA, bus_if.OP_RB, bus_if.OP_DATA);
            f = plan.pop_front();
            nready = 1'b0;
        end else begin
            f = idle_f();
            nready = 1'b1;
        end
        @(posedge clk);
        #1;
        cyc++;
        cur = f;
        m_ready = nready;
        if (was_rst) begin
            m_ax = 4'd0;
            m_bx = 4'd0;
        end else begin
            if (f.ax_set) m_ax = f.ax;
            if (f.bx_set) m_bx = f.bx;
        end
        chk("ready",   32'(bus_if.OP_READY), 32'(m_ready));
        chk("done",    32'(bus_if.OP_DONE),  32'(cur.done));
        chk("err",     32'(bus_if.OP_ERR),   32'(cur.err));
        chk("regaopx", 32'(bus_if.REGAOPX),  32'(cur.aop));
        chk("regbopx", 32'(bus_if.REGBOPX),  32'(cur.bop));
        chk("din",     32'(bus_if.DIN),      32'(cur.din));
        chk("regax",   32'(bus_if.REGAX),    32'(m_ax));
        chk("regbx",   32'(bus_if.REGBX),    32'(m_bx));
        k = 0;
        for (int i = 15; i >= 0; i--) if (rf[i] !== model_rf[i]) k = i;
        chk("regfile", 32'(rf[k]), 32'(model_rf[k]));
    endtask

    // Issue one op, wait for its completion, and snapshot first-cycle outputs.
    task automatic do_op(input logic [2:0] c, input logic [3:0] ra, input logic [3:0] rb,
                         input logic [15:0] data);
        int guard;
        guard = 0;
        while (!m_ready && guard < 20) begin cycle(); guard++; end
        if (!m_ready) chk("ready_timeout", 32'(m_ready), 32'd1);
        bus_if.OP_VALID = 1'b1;
        bus_if.OP_CODE  = c;
        bus_if.OP_RA    = ra;
        bus_if.OP_RB    = rb;
        bus_if.OP_DATA  = data;
        cycle();
        bus_if.OP_VALID = 1'b0;
        s_ax   = bus_if.REGAX;
        s_aop  = bus_if.REGAOPX;
        s_bop  = bus_if.REGBOPX;
        s_din  = bus_if.DIN;
        s_done = bus_if.OP_DONE;
        s_err  = bus_if.OP_ERR;
        s_busy = bus_if.OP_READY ? 0 : 1;
        guard = 0;
        while (plan.size() != 0 && guard < 10) begin
            cycle();
            guard++;
            if (!bus_if.OP_READY) s_busy++;
        end
        cycle();
        if (!bus_if.OP_READY) s_busy++;
    endtask

    logic [15:0] pc0;
    int          c0;

    initial begin
        rst = 1'b1;
        rf_init = 1'b1;
        bus_if.OP_VALID = 1'b0;
        bus_if.OP_CODE  = 3'd0;
        bus_if.OP_RA    = 4'd0;
        bus_if.OP_RB    = 4'd0;
        bus_if.OP_DATA  = 16'd0;
        for (int i = 0; i < 16; i++) init_vals[i] = 16'($urandom);
        @(posedge clk);
        #1;
        rf_init = 1'b0;
        for (int i = 0; i < 16; i++) model_rf[i] = init_vals[i];
        cur = idle_f();
        m_ready = 1'b0;
        m_ax = 4'd0;
        m_bx = 4'd0;
        cycle();
        chk("rst_ready_low", 32'(bus_if.OP_READY), 32'd0);
        chk("rst_regax", 32'(bus_if.REGAX), 32'd0);
        rst = 1'b0;
        cycle();
        cycle();
        chk("ready_after_rst", 32'(bus_if.OP_READY), 32'd1);

        // LOAD R3 <= BEEF
        do_op(3'd1, 4'd3, 4'd0, 16'hBEEF);
        chk("load_regax", 32'(s_ax), 32'd3);
        chk("load_aop", 32'(s_aop), 32'd1);
        chk("load_din", 32'(s_din), 32'h0000BEEF);
        chk("load_done", 32'(s_done), 32'd1);
        chk("load_r3", 32'(rf[3]), 32'h0000BEEF);

        // INC/DEC wrap on R2
        do_op(3'd1, 4'd2, 4'd0, 16'hFFFF);
        do_op(3'd2, 4'd0, 4'd2, 16'h0000);
        chk("inc_done", 32'(s_done), 32'd1);
        chk("inc_wrap", 32'(rf[2]), 32'h00000000);
        do_op(3'd3, 4'd0, 4'd2, 16'h0000);
        chk("dec_wrap", 32'(rf[2]), 32'h0000FFFF);

        // SWAP R1/R4
        do_op(3'd1, 4'd1, 4'd0, 16'h1234);
        do_op(3'd1, 4'd4, 4'd0, 16'hABCD);
        do_op(3'd5, 4'd1, 4'd4, 16'h0000);
        chk("swap_first_done", 32'(s_done), 32'd0);
        chk("swap_busy", 32'(s_busy), 32'd3);
        chk("swap_r1", 32'(rf[1]), 32'h0000ABCD);
        chk("swap_r4", 32'(rf[4]), 32'h00001234);

        // MOVE R7 <= R1
        do_op(3'd4, 4'd7, 4'd1, 16'h0000);
        chk("move_busy", 32'(s_busy), 32'd2);
        chk("move_r7", 32'(rf[7]), 32'h0000ABCD);

        // INC on PC is rejected
        pc0 = rf[15];
        c0 = cyc;
        do_op(3'd2, 4'd0, 4'd15, 16'h0000);
        chk("inc_pc_err", 32'(s_err), 32'd1);
        chk("inc_pc_bop", 32'(s_bop), 32'd0);
        chk("pc_advance", 32'(rf[15]), 32'(16'(pc0 + 16'(cyc - c0))));

        // Reserved opcode
        do_op(3'd7, 4'd9, 4'd9, 16'h5555);
        chk("rsvd_err", 32'(s_err), 32'd1);
        chk("rsvd_aop", 32'(s_aop), 32'd0);

        // LDINC, disjoint and colliding
        do_op(3'd1, 4'd6, 4'd0, 16'h0009);
        do_op(3'd6, 4'd5, 4'd6, 16'h0007);
        chk("ldinc_r5", 32'(rf[5]), 32'h00000007);
        chk("ldinc_r6", 32'(rf[6]), 32'h0000000A);
        do_op(3'd1, 4'd5, 4'd0, 16'h0055);
        do_op(3'd6, 4'd5, 4'd5, 16'h0007);
        chk("ldinc_same_bop", 32'(s_bop), 32'd0);
        chk("ldinc_same_r5", 32'(rf[5]), 32'h00000007);

        // RESET for 2 cycles right after SWAP EX1
        do_op(3'd1, 4'd1, 4'd0, 16'h1234);
        do_op(3'd1, 4'd4, 4'd0, 16'hABCD);
        bus_if.OP_VALID = 1'b1;
        bus_if.OP_CODE  = 3'd5;
        bus_if.OP_RA    = 4'd1;
        bus_if.OP_RB    = 4'd4;
        cycle();
        bus_if.OP_VALID = 1'b0;
        rst = 1'b1;
        cycle();
        chk("abort_aop", 32'(bus_if.REGAOPX), 32'd0);
        cycle();
        rst = 1'b0;
        cycle();
        chk("abort_ready", 32'(bus_if.OP_READY), 32'd1);
        chk("abort_done", 32'(bus_if.OP_DONE), 32'd0);
        chk("abort_r1", 32'(rf[1]), 32'h00001234);
        chk("abort_r4", 32'(rf[4]), 32'h0000ABCD);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 1500; i++) begin
            rst = ($urandom_range(0, 149) == 0);
            bus_if.OP_VALID = 1'($urandom_range(0, 1));
            bus_if.OP_CODE  = 3'($urandom_range(0, 7));
            bus_if.OP_RA    = 4'($urandom_range(0, 15));
            bus_if.OP_RB    = 4'($urandom_range(0, 15));
            bus_if.OP_DATA  = 16'($urandom);
            cycle();
        end
        rst = 1'b0;
        bus_if.OP_VALID = 1'b0;
        for (int i = 0; i < 6; i++) cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
